branch_pc_unit: RTL and testbench
=================================

Name: branch_pc_unit

Overview:
- Parametrised successor to the combinational branch-target formatter. Adds a registered program counter, stall handling, branch-op modes (relative, absolute, call, return) and a circular return-address stack (RAS).
- Sits in the processor fetch stage and drives the instruction-memory address. Decode/execute supply the branch op, condition, register value and sign-extended immediate.

Parameters:
ADDR_W, 8, PC / instruction address width in bits (>=2)
DATA_W, 32, width of RegValue and ImmExt (>= ADDR_W)
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)
RESET_PC, 0, PC value loaded on reset (ADDR_W bits)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Stall  in  1  hold PC, stack and flags this cycle
BranchValid  in  1  a branch instruction is presented this cycle
BranchOp  in  2  00 REL (PC+ImmExt), 01 ABS (RegValue), 10 CALL (PC+ImmExt, push PC+1), 11 RET (pop)
Taken  in  1  branch condition result; branch acts only if BranchValid && Taken
RegValue  in  DATA_W  register operand for ABS
ImmExt  in  DATA_W  sign-extended two's-complement offset for REL/CALL
PC  out  ADDR_W  current program counter (registered)
Redirect  out  1  registered pulse: PC was loaded from a non-sequential target last edge
RasDepth  out  $clog2(RAS_DEPTH)+1  valid entries in the stack
StackOverflow  out  1  sticky: CALL issued with stack full
StackUnderflow  out  1  sticky: RET issued with stack empty

Behaviour:
- Reset (async, any time, including mid-operation): PC=RESET_PC, Redirect=0, RasDepth=0, both flags 0. Stack contents are don't-care but are unreachable because depth is 0.
- All updates occur on the rising Clk edge. Outputs are purely registered, so a new PC is visible 1 cycle after the request.
- Stall=1 takes priority. PC, stack, depth and flags hold; Redirect<=0; branch inputs are ignored (not queued).
- Stall=0 and no taken branch (BranchValid=0 or Taken=0): PC<=PC+1 mod 2^ADDR_W; Redirect<=0.
- Stall=0 and taken branch:
  - REL: PC<=(PC + ImmExt)[ADDR_W-1:0]. The sum is computed at DATA_W and truncated, so it wraps modulo 2^ADDR_W in both directions. Redirect<=1.
  - ABS: PC<=RegValue[ADDR_W-1:0]; upper bits are ignored. Redirect<=1.
  - CALL: PC as REL; push (PC+1) mod 2^ADDR_W; Redirect<=1.
    - Not full: RasDepth+1.
    - Full: overwrite the oldest entry (circular), RasDepth stays RAS_DEPTH, StackOverflow<=1.
  - RET, non-empty: PC<=top entry; RasDepth-1; Redirect<=1.
  - RET, empty: PC<=PC+1; StackUnderflow<=1; Redirect<=0.
- Redirect is 1 even when the target equals PC+1, i.e. it flags source, not value.
- Stack is LIFO over the newest RAS_DEPTH pushes. After overflow, RAS_DEPTH pops return the newest RAS_DEPTH addresses in reverse push order; the next pop underflows.
- Flags clear only on Reset.
- Unknown/X on BranchOp while BranchValid=0 must not affect state.

Test Plan:
- Reset then 3 idle cycles: PC=00,01,02,03; Redirect=0; RasDepth=0; flags 0. Assert Reset asynchronously mid-cycle at PC=03 -> PC=00 immediately, before the next edge.
- REL wrap: PC=FE, REL ImmExt=32'h00000005 -> PC=03, Redirect=1 for one cycle. PC=02, REL ImmExt=32'hFFFFFFFC -> PC=FE.
- ABS: RegValue=32'hDEADBE42 -> PC=42. Same request with Taken=0 -> PC=old+1, Redirect=0. Same request with Stall=1 -> PC unchanged.
- CALL/RET: at PC=10 CALL ImmExt=+0x20 -> PC=30, RasDepth=1. At PC=35 CALL ImmExt=+0x10 -> PC=45, RasDepth=2. RET -> PC=36. RET -> PC=11. RasDepth=0.
- Overflow (RAS_DEPTH=4): 5 CALLs pushing 01,02,03,04,05 -> StackOverflow=1, RasDepth=4. 4 RETs -> PC=05,04,03,02. 5th RET -> PC=prev+1, StackUnderflow=1, Redirect=0.
- Stall during CALL with Stall=1: no push, RasDepth unchanged. Release Stall with the same inputs -> push occurs exactly once.

Source files
------------

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: registered fetch PC with relative/absolute/call/return branching and a circular return-address stack.
module branch_pc_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Stall,
  input  logic                         BranchValid,
  input  logic [1:0]                   BranchOp,
  input  logic                         Taken,
  input  logic [DATA_W-1:0]            RegValue,
  input  logic [DATA_W-1:0]            ImmExt,
  output logic [ADDR_W-1:0]            PC,
  output logic                         Redirect,
  output logic [$clog2(RAS_DEPTH):0]   RasDepth,
  output logic                         StackOverflow,
  output logic                         StackUnderflow
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [ADDR_W-1:0] pcSeq, retPc, nextPc;
  logic [DATA_W-1:0] relSum;
  logic takenBr, isCall, isRet, rasEmpty, rasFull, doPop, redirectNext;
  logic unusedBits;
  always_comb begin
    takenBr = BranchValid && Taken && !Stall;
    isCall = takenBr && BranchOp == 2'b10;
    isRet = takenBr && BranchOp == 2'b11;
    rasEmpty = RasDepth == '0;
    rasFull = RasDepth == (PTR_W + 1)'(RAS_DEPTH);
    doPop = isRet && !rasEmpty;
    pcSeq = PC + ADDR_W'(1);
    relSum = DATA_W'(PC) + ImmExt;
    retPc = ras[wrPtr - PTR_W'(1)];
    redirectNext = takenBr && !(isRet && rasEmpty);
    nextPc = !redirectNext ? pcSeq :
             BranchOp == 2'b01 ? RegValue[ADDR_W-1:0] :
             BranchOp == 2'b11 ? retPc : relSum[ADDR_W-1:0];
    unusedBits = ^{RegValue, relSum};
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      PC <= RESET_PC;
      Redirect <= 1'b0;
      RasDepth <= '0;
      wrPtr <= '0;
      StackOverflow <= 1'b0;
      StackUnderflow <= 1'b0;
    end else begin
      PC <= Stall ? PC : nextPc;
      Redirect <= redirectNext;
      // A full stack keeps its depth; the push wraps over the oldest entry.
      if (isCall && !rasFull) RasDepth <= RasDepth + 1'b1;
      if (doPop) RasDepth <= RasDepth - 1'b1;
      if (isCall) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop) wrPtr <= wrPtr - PTR_W'(1);
      if (isCall && rasFull) StackOverflow <= 1'b1;
      if (isRet && rasEmpty) StackUnderflow <= 1'b1;
    end
  end
  always_ff @(posedge Clk) begin
    if (isCall) ras[wrPtr] <= pcSeq;
  end
endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit: directed vectors with a queued scoreboard checked after each clock edge.
module tb_branch_pc_unit;
  logic Clk = 0, Reset = 1, Stall = 0, BranchValid = 0, Taken = 0;
  logic [1:0] BranchOp = 0;
  logic [31:0] RegValue = 0, ImmExt = 0;
  logic [7:0] PC;
  logic Redirect, StackOverflow, StackUnderflow;
  logic [2:0] RasDepth;
  int passed = 0, total = 0;

  typedef struct packed {
    logic [7:0] pc;
    logic red;
    logic [2:0] dep;
    logic ovf;
    logic unf;
  } exp_t;
  exp_t q[$];

  branch_pc_unit #(.ADDR_W(8), .DATA_W(32), .RAS_DEPTH(4), .RESET_PC(8'h00)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchValid(BranchValid),
    .BranchOp(BranchOp), .Taken(Taken), .RegValue(RegValue), .ImmExt(ImmExt),
    .PC(PC), .Redirect(Redirect), .RasDepth(RasDepth),
    .StackOverflow(StackOverflow), .StackUnderflow(StackUnderflow)
  );

  always #5 Clk = ~Clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    else passed++;
  endfunction

  function automatic void chkAll(string tag, exp_t e);
    chk({tag, ".PC"}, 32'(PC), 32'(e.pc));
    chk({tag, ".Redirect"}, 32'(Redirect), 32'(e.red));
    chk({tag, ".RasDepth"}, 32'(RasDepth), 32'(e.dep));
    chk({tag, ".Overflow"}, 32'(StackOverflow), 32'(e.ovf));
    chk({tag, ".Underflow"}, 32'(StackUnderflow), 32'(e.unf));
  endfunction

  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (q.size() != 0) chkAll("cycle", q.pop_front());
    end
  end

  task automatic step(input logic st, bv, tk, input logic [1:0] op, input logic [31:0] rv, im,
                      input logic [7:0] pc, input logic red, input logic [2:0] dep, input logic ovf, unf);
    Stall = st; BranchValid = bv; Taken = tk; BranchOp = op; RegValue = rv; ImmExt = im;
    q.push_back('{pc, red, dep, ovf, unf});
    @(negedge Clk);
  endtask

  initial begin
    @(negedge Clk);
    Reset = 0;
    chkAll("reset", '{8'h00, 1'b0, 3'd0, 1'b0, 1'b0});
    step(0, 0, 0, 2'b00, 0, 0, 8'h01, 0, 0, 0, 0);
    step(0, 0, 0, 2'b00, 0, 0, 8'h02, 0, 0, 0, 0);
    step(0, 0, 0, 2'b00, 0, 0, 8'h03, 0, 0, 0, 0);
    #2 Reset = 1;
    #1 chkAll("asyncReset", '{8'h00, 1'b0, 3'd0, 1'b0, 1'b0});
    @(negedge Clk);
    Reset = 0;
    // REL wrap in both directions
    step(0, 1, 1, 2'b01, 32'h000000FE, 0, 8'hFE, 1, 0, 0, 0);
    step(0, 1, 1, 2'b00, 0, 32'h00000005, 8'h03, 1, 0, 0, 0);
    step(0, 0, 0, 2'b00, 0, 0, 8'h04, 0, 0, 0, 0);
    step(0, 1, 1, 2'b01, 32'h00000002, 0, 8'h02, 1, 0, 0, 0);
    step(0, 1, 1, 2'b00, 0, 32'hFFFFFFFC, 8'hFE, 1, 0, 0, 0);
    // ABS, not taken, stalled, and X op while invalid
    step(0, 1, 1, 2'b01, 32'hDEADBE42, 0, 8'h42, 1, 0, 0, 0);
    step(0, 1, 0, 2'b01, 32'hDEADBE42, 0, 8'h43, 0, 0, 0, 0);
    step(1, 1, 1, 2'b01, 32'hDEADBE42, 0, 8'h43, 0, 0, 0, 0);
    step(0, 0, 1, 2'bxx, 32'hDEADBE42, 32'h11, 8'h44, 0, 0, 0, 0);
    // CALL/RET nesting
    step(0, 1, 1, 2'b01, 32'h10, 0, 8'h10, 1, 0, 0, 0);
    step(0, 1, 1, 2'b10, 0, 32'h20, 8'h30, 1, 1, 0, 0);
    step(0, 1, 1, 2'b01, 32'h35, 0, 8'h35, 1, 1, 0, 0);
    step(0, 1, 1, 2'b10, 0, 32'h10, 8'h45, 1, 2, 0, 0);
    step(0, 1, 1, 2'b11, 0, 0, 8'h36, 1, 1, 0, 0);
    step(0, 1, 1, 2'b11, 0, 0, 8'h11, 1, 0, 0, 0);
    // overflow: five CALLs with target PC+1 push 01..05
    step(0, 1, 1, 2'b01, 32'h00, 0, 8'h00, 1, 0, 0, 0);
    step(0, 1, 1, 2'b10, 0, 32'h1, 8'h01, 1, 1, 0, 0);
    step(0, 1, 1, 2'b10, 0, 32'h1, 8'h02, 1, 2, 0, 0);
    step(0, 1, 1, 2'b10, 0, 32'h1, 8'h03, 1, 3, 0, 0);
    step(0, 1, 1, 2'b10, 0, 32'h1, 8'h04, 1, 4, 0, 0);
    step(0, 1, 1, 2'b10, 0, 32'h1, 8'h05, 1, 4, 1, 0);
    step(0, 1, 1, 2'b11, 0, 0, 8'h05, 1, 3, 1, 0);
    step(0, 1, 1, 2'b11, 0, 0, 8'h04, 1, 2, 1, 0);
    step(0, 1, 1, 2'b11, 0, 0, 8'h03, 1, 1, 1, 0);
    step(0, 1, 1, 2'b11, 0, 0, 8'h02, 1, 0, 1, 0);
    step(0, 1, 1, 2'b11, 0, 0, 8'h03, 0, 0, 1, 1);
    // stalled CALL pushes exactly once on release
    step(1, 1, 1, 2'b10, 0, 32'h10, 8'h03, 0, 0, 1, 1);
    step(1, 1, 1, 2'b10, 0, 32'h10, 8'h03, 0, 0, 1, 1);
    step(0, 1, 1, 2'b10, 0, 32'h10, 8'h13, 1, 1, 1, 1);
    step(0, 0, 0, 2'b00, 0, 0, 8'h14, 0, 1, 1, 1);
    step(0, 1, 1, 2'b11, 0, 0, 8'h04, 1, 0, 1, 1);
    step(0, 1, 1, 2'b11, 0, 0, 8'h05, 0, 0, 1, 1);
    BranchValid = 0; Taken = 0;
    repeat (3) @(posedge Clk);
    #2;
    chk("scoreboardDrained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
